// File: rtl/pio_bidir_seq.sv
// pio_bidir_seq -- half-duplex single-wire transaction sequencer feeding a
// BB bidirectional pad buffer (I = pad_o, T = pad_t, O = pad_i).
//
// A write serialises cmd_data MSB-first with BIT_DIV clocks per bit. The pad
// is then released for TURN_CYCLES, and a one-cycle rsp_valid follows.
// A read releases the pad for TURN_CYCLES first. It then samples WIDTH bits
// MSB-first at phase BIT_DIV/2 of each bit period, and returns the word on
// rsp_data together with rsp_valid.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (aborts any transaction)
//   cmd_valid  command request; accepted when cmd_ready is high
//   cmd_ready  high only in IDLE (and not in reset)
//   cmd_write  1 = write (transmit), 0 = read (receive); sampled on accept
//   cmd_data   transmit word; sampled on accept
//   rsp_valid  one-cycle completion pulse, no backpressure
//   rsp_data   received word for reads, zero for writes
//   busy       high whenever not IDLE
//   pad_o      to BB.I, registered
//   pad_t      to BB.T, registered, 1 = high-Z; low only during TX
//   pad_i      from BB.O
//
// Optional build macro PIO_PAD_SYNC_EN: pad_i goes through a 2-flop
// synchroniser (reset to 1) before it is sampled. The sample point is
// unchanged, so the sampled value is two cycles older.
module pio_bidir_seq #(
   parameter int WIDTH       = 8,
   parameter int BIT_DIV     = 4,
   parameter int TURN_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             rsp_valid,
   output logic [WIDTH-1:0] rsp_data,
   output logic             busy,
   output logic             pad_o,
   output logic             pad_t,
   input  logic             pad_i
);

   localparam int PW = $clog2(BIT_DIV);
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

   localparam logic [PW-1:0] LAST_PH   = PW'(BIT_DIV - 1);
   localparam logic [PW-1:0] SAMPLE_PH = PW'(BIT_DIV / 2);
   localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
   localparam logic [TW-1:0] LAST_TURN = TW'(TURN_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, TX, TURN, RX, DONE} state_t;

   state_t           state, state_nx;
   logic [PW-1:0]    phase, phase_nx;
   logic [BW-1:0]    bitc, bitc_nx;
   logic [TW-1:0]    turn, turn_nx;
   logic [WIDTH-1:0] shift, shift_nx;
   logic             dir, dir_nx;     // 1 = write transaction in flight
   logic             pad_s;           // pad level as seen by the RX sampler

`ifdef PIO_PAD_SYNC_EN
   logic sync1, sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= pad_i;
         sync2 <= sync1;
      end
   end

   assign pad_s = sync2;
`else
   assign pad_s = pad_i;
`endif

   assign cmd_ready = (state == IDLE) && !rst;
   assign busy      = (state != IDLE);

   always_comb begin
      state_nx = state;
      phase_nx = phase;
      bitc_nx  = bitc;
      turn_nx  = turn;
      shift_nx = shift;
      dir_nx   = dir;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               shift_nx = cmd_data;
               dir_nx   = cmd_write;
               phase_nx = '0;
               bitc_nx  = '0;
               turn_nx  = '0;
               state_nx = cmd_write ? TX : TURN;
            end
         end
         TX: begin
            if (phase == LAST_PH) begin
               phase_nx = '0;
               shift_nx = shift << 1;
               if (bitc == LAST_BIT) begin
                  state_nx = TURN;
                  turn_nx  = '0;
               end else begin
                  bitc_nx = bitc + 1'b1;
               end
            end else begin
               phase_nx = phase + 1'b1;
            end
         end
         TURN: begin
            if (turn == LAST_TURN) begin
               turn_nx  = '0;
               phase_nx = '0;
               bitc_nx  = '0;
               state_nx = dir ? DONE : RX;
            end else begin
               turn_nx = turn + 1'b1;
            end
         end
         RX: begin
            // Sample first: with BIT_DIV=2 the sample phase is also the
            // last phase, so the final bit must land before DONE.
            if (phase == SAMPLE_PH)
               shift_nx = (shift << 1) | WIDTH'(pad_s);
            if (phase == LAST_PH) begin
               phase_nx = '0;
               if (bitc == LAST_BIT)
                  state_nx = DONE;
               else
                  bitc_nx = bitc + 1'b1;
            end else begin
               phase_nx = phase + 1'b1;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Pad and response outputs are registered from the next-state values,
   // so they change on the same edge as the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         phase     <= '0;
         bitc      <= '0;
         turn      <= '0;
         dir       <= 1'b0;
         pad_o     <= 1'b1;
         pad_t     <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         state     <= state_nx;
         phase     <= phase_nx;
         bitc      <= bitc_nx;
         turn      <= turn_nx;
         dir       <= dir_nx;
         pad_t     <= (state_nx != TX);
         pad_o     <= (state_nx == TX) ? shift_nx[WIDTH-1] : 1'b1;
         rsp_valid <= (state_nx == DONE);
         rsp_data  <= (state_nx == DONE && !dir_nx) ? shift_nx : '0;
      end
   end

   always_ff @(posedge clk) begin
      shift <= shift_nx;
   end

endmodule

// File: tb/tb_pio_bidir_seq.sv
// Testbench for pio_bidir_seq. The bench uses two instances:
//   d0: WIDTH=8, BIT_DIV=4, TURN_CYCLES=2 (main traffic)
//   d1: WIDTH=1, BIT_DIV=2, TURN_CYCLES=1 (boundary case)
// The stimulus pushes expected responses (data and arrival cycle) into
// per-instance queues. A monitor pops and compares on every rsp_valid.
module tb_pio_bidir_seq;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t q0[$];
   exp_t q1[$];

   logic       cmd_valid0, cmd_ready0, cmd_write0, rsp_valid0, busy0;
   logic       pad_o0, pad_t0, pad_i0;
   logic [7:0] cmd_data0, rsp_data0;

   logic       cmd_valid1, cmd_ready1, cmd_write1, rsp_valid1, busy1;
   logic       pad_o1, pad_t1, pad_i1;
   logic [0:0] cmd_data1, rsp_data1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pio_bidir_seq #(.WIDTH(8), .BIT_DIV(4), .TURN_CYCLES(2)) d0 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
      .cmd_write(cmd_write0), .cmd_data(cmd_data0), .rsp_valid(rsp_valid0),
      .rsp_data(rsp_data0), .busy(busy0), .pad_o(pad_o0), .pad_t(pad_t0),
      .pad_i(pad_i0));

   pio_bidir_seq #(.WIDTH(1), .BIT_DIV(2), .TURN_CYCLES(1)) d1 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
      .cmd_write(cmd_write1), .cmd_data(cmd_data1), .rsp_valid(rsp_valid1),
      .rsp_data(rsp_data1), .busy(busy1), .pad_o(pad_o1), .pad_t(pad_t1),
      .pad_i(pad_i1));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, req);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid0 === 1'b1) begin
         if (q0.size() == 0) begin
            check("d0_unexpected_rsp", 32'd1, 32'd0);
         end else begin
            e = q0.pop_front();
            check("d0_rsp_data", {24'd0, rsp_data0}, {24'd0, e.data});
            check("d0_rsp_cycle", cyc, e.cyc);
         end
      end
      if (rsp_valid1 === 1'b1) begin
         if (q1.size() == 0) begin
            check("d1_unexpected_rsp", 32'd1, 32'd0);
         end else begin
            e = q1.pop_front();
            check("d1_rsp_data", {31'd0, rsp_data1}, {24'd0, e.data});
            check("d1_rsp_cycle", cyc, e.cyc);
         end
      end
   end

   // One d0 transaction. The call must be made at a negedge. Cycle n
   // is the n-th cycle after the accept edge.
   task automatic txn0(input bit wr, input logic [7:0] d, input logic [7:0] pw,
                       input int align, input logic [7:0] req, input bit hold);
      int k;
      int e;
      logic et, eo;
      k = 0;
      while (cmd_ready0 !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) check("d0_ready_timeout", 32'd0, 32'd1);
      cmd_valid0 = 1'b1;
      cmd_write0 = wr;
      cmd_data0  = d;
      e = cyc;
      q0.push_back('{req, e + 35});
      for (int n = 1; n <= 36; n++) begin
         @(negedge clk);
         if (hold && n <= 35) begin
            cmd_valid0 = 1'b1;
            cmd_write0 = 1'b0;
            cmd_data0  = 8'hFF;
         end else begin
            cmd_valid0 = 1'b0;
         end
         pad_i0 = (!wr && n >= align && n < align + 32) ? pw[7 - (n - align) / 4] : 1'b1;
         et = (wr && n <= 32) ? 1'b0 : 1'b1;
         eo = (wr && n <= 32) ? d[7 - (n - 1) / 4] : 1'b1;
         check("d0_pad_t", {31'd0, pad_t0}, {31'd0, et});
         check("d0_pad_o", {31'd0, pad_o0}, {31'd0, eo});
         if (n == 20) check("d0_busy", {31'd0, busy0}, 32'd1);
         if (n == 36) check("d0_ready_after_rsp", {31'd0, cmd_ready0}, 32'd1);
      end
      cmd_valid0 = 1'b0;
   endtask

   task automatic txn1(input bit wr, input logic d, input logic pv, input logic req);
      int k;
      int e;
      logic et, eo;
      k = 0;
      while (cmd_ready1 !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) check("d1_ready_timeout", 32'd0, 32'd1);
      cmd_valid1   = 1'b1;
      cmd_write1   = wr;
      cmd_data1[0] = d;
      e = cyc;
      q1.push_back('{{7'd0, req}, e + 4});
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         cmd_valid1 = 1'b0;
         pad_i1 = pv;
         et = (wr && n <= 2) ? 1'b0 : 1'b1;
         eo = (wr && n <= 2) ? d : 1'b1;
         check("d1_pad_t", {31'd0, pad_t1}, {31'd0, et});
         check("d1_pad_o", {31'd0, pad_o1}, {31'd0, eo});
         if (n == 5) check("d1_ready_after_rsp", {31'd0, cmd_ready1}, 32'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      logic [7:0] shifted_req;
      rst = 1'b1;
      cmd_valid0 = 1'b0; cmd_write0 = 1'b0; cmd_data0 = 8'h00; pad_i0 = 1'b1;
      cmd_valid1 = 1'b0; cmd_write1 = 1'b0; cmd_data1 = 1'b0;  pad_i1 = 1'b1;
      repeat (3) @(negedge clk);

      check("rst_cmd_ready", {31'd0, cmd_ready0}, 32'd0);
      check("rst_busy", {31'd0, busy0}, 32'd0);
      check("rst_pad_t", {31'd0, pad_t0}, 32'd1);
      check("rst_pad_o", {31'd0, pad_o0}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid0}, 32'd0);
      check("rst_rsp_data", {24'd0, rsp_data0}, 32'd0);
      check("rst_d1_pad_t", {31'd0, pad_t1}, 32'd1);

      rst = 1'b0;
      #1;
      check("ready_after_rst", {31'd0, cmd_ready0}, 32'd1);
      check("d1_ready_after_rst", {31'd0, cmd_ready1}, 32'd1);

      // Writes and reads with distinct patterns.
      txn0(1'b1, 8'hA5, 8'h00, 0, 8'h00, 1'b0);
      txn0(1'b0, 8'h00, 8'h3C, 3, 8'h3C, 1'b0);
      txn0(1'b1, 8'h3C, 8'h00, 0, 8'h00, 1'b0);
      txn0(1'b0, 8'hFF, 8'hC3, 3, 8'hC3, 1'b0);

      // cmd_valid held high with cmd_data=0xFF while busy: it must be ignored.
      txn0(1'b1, 8'h0F, 8'h00, 0, 8'h00, 1'b1);

      // Abort a write in cycle 10 with reset.
      cmd_valid0 = 1'b1; cmd_write0 = 1'b1; cmd_data0 = 8'hA5;
      e = cyc;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         cmd_valid0 = 1'b0;
      end
      check("abort_busy_before", {31'd0, busy0}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_pad_t", {31'd0, pad_t0}, 32'd1);
      check("abort_pad_o", {31'd0, pad_o0}, 32'd1);
      check("abort_busy", {31'd0, busy0}, 32'd0);
      check("abort_ready_in_rst", {31'd0, cmd_ready0}, 32'd0);
      check("abort_cycle", cyc - e, 32'd11);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      txn0(1'b0, 8'h00, 8'h96, 3, 8'h96, 1'b0);

      // Read with pad data presented 2 cycles early. The synchroniser
      // realigns it; without it, every bit is taken one period late.
`ifdef PIO_PAD_SYNC_EN
      shifted_req = 8'h3C;
`else
      shifted_req = 8'h79;
`endif
      txn0(1'b0, 8'h00, 8'h3C, 1, shifted_req, 1'b0);

      // WIDTH=1, BIT_DIV=2, TURN_CYCLES=1 boundary.
      txn1(1'b0, 1'b0, 1'b1, 1'b1);
      txn1(1'b0, 1'b1, 1'b0, 1'b0);
      txn1(1'b1, 1'b0, 1'b1, 1'b0);

      repeat (10) @(negedge clk);
      check("d0_queue_drained", q0.size(), 32'd0);
      check("d1_queue_drained", q1.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
